// File: rtl/nano_pkg.sv
// Shared types and constants for the nano_mem block: address/word types,
// the controller state enum and the default memory-map constants.
package nano_pkg;

    typedef logic [7:0]  addr_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } mem_state_t;

    localparam addr_t IO_ADDR_DEFAULT = 8'hFF;
    localparam addr_t WP_TOP_DEFAULT  = 8'h0F;
    localparam int unsigned DEPTH     = 256;
    localparam addr_t CLEAR_LAST      = 8'hFF;

endpackage

// File: rtl/nano_mem_array.sv
// 256 x 16 storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the controller zeroes them with its clear sweep.
module nano_mem_array
    import nano_pkg::*;
(
    input  logic  ck,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  word_t wr_data,
    input  addr_t rd_addr,
    output word_t rd_data
);

    word_t mem [DEPTH];

    // Single write port, committed on the rising edge.
    always_ff @(posedge ck) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nano_mem.sv
// nano_mem: program/data memory for the NanoCPU with a clear -> load -> run
// controller, a write-protected code region, and a memory-mapped output
// register. Optional statistics counters are enabled by NANO_MEM_STATS_EN.
//
// Loader handshake: ld_valid has no ready partner. While in LOAD every cycle
// with ld_valid=1 is accepted unconditionally and written at that clock edge;
// outside LOAD ld_valid and ld_done are ignored.
//
// Debug: 'state' exposes the controller state. dbg_addr drives the array read
// port outside RUN and dbg_data shows the raw array word at the selected
// address (in RUN the read port follows the CPU address).
module nano_mem
    import nano_pkg::*;
#(
    parameter addr_t WP_TOP  = WP_TOP_DEFAULT,
    parameter addr_t IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic       ck,
    input  logic       rst,
    input  addr_t      address,
    input  word_t      dataW,
    output word_t      dataR,
    input  logic       ce,
    input  logic       we,
    input  logic       ld_valid,
    input  addr_t      ld_addr,
    input  word_t      ld_data,
    input  logic       ld_done,
    output logic       cpu_rst,
    output logic       busy,
    output word_t      io_out,
    output logic       io_strobe,
    output logic       wp_fault,
    input  addr_t      dbg_addr,
    output word_t      dbg_data,
    output mem_state_t state
`ifdef NANO_MEM_STATS_EN
    ,
    output word_t      rd_count,
    output word_t      wr_count
`endif
);

    mem_state_t state_next;
    addr_t      cnt;
    logic       wr_en;
    addr_t      wr_addr;
    word_t      wr_data;
    addr_t      rd_addr;
    word_t      rd_data;
    logic       run;
    logic       cpu_write;
    logic       io_hit;
    logic       wp_hit;

    assign run       = (state == RUN);
    assign cpu_write = run && ce && we;
    assign io_hit    = (address == IO_ADDR);
    // The output register takes priority over the protected range.
    assign wp_hit    = !io_hit && (address <= WP_TOP);

    assign cpu_rst   = (state != RUN);
    assign busy      = (state == CLEAR);

    // State register.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Clear sweep counter: walks 0..255 while clearing, parked at 0 otherwise.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Next-state logic and the array write mux (clear / loader / CPU).
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = cnt;
        wr_data    = '0;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = '0;
                if (cnt == CLEAR_LAST) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                wr_en   = ld_valid;
                wr_addr = ld_addr;
                wr_data = ld_data;
                if (ld_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                wr_en   = cpu_write && !io_hit && !wp_hit;
                wr_addr = address;
                wr_data = dataW;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Output register and the one-cycle strobe / fault pulses.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            io_out    <= '0;
            io_strobe <= 1'b0;
            wp_fault  <= 1'b0;
        end else begin
            io_strobe <= cpu_write && io_hit;
            wp_fault  <= cpu_write && wp_hit;
            if (cpu_write && io_hit) begin
                io_out <= dataW;
            end
        end
    end

    assign rd_addr  = run ? address : dbg_addr;
    assign dbg_data = rd_data;

    // CPU read data: zero unless an enabled access is made in RUN.
    always_comb begin
        dataR = '0;
        if (run && ce) begin
            dataR = io_hit ? io_out : rd_data;
        end
    end

    nano_mem_array u_array (
        .ck      (ck),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef NANO_MEM_STATS_EN
    logic rd_acc;
    logic wr_acc;

    assign rd_acc = run && ce && !we;
    assign wr_acc = cpu_write && !wp_hit;

    // Saturating counts of accepted reads and writes in RUN.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_acc && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_acc && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/nano_mem.md
NANO_MEM -- requirements
Module: nano_mem

Interface
REQ-001 Parameter WP_TOP, default 8'h0F, highest address of the write-protected code region; CPU writes to 0..WP_TOP are blocked.
REQ-002 Parameter IO_ADDR, default 8'hFF, address of the memory-mapped output register.
REQ-003 ck  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 address  input  8  CPU word address.
REQ-006 dataW  input  16  CPU write data.
REQ-007 dataR  output  16  CPU read data.
REQ-008 ce  input  1  CPU access enable.
REQ-009 we  input  1  CPU write enable; ignored unless ce=1.
REQ-010 ld_valid  input  1  host loader word valid.
REQ-011 ld_addr  input  8  host loader address.
REQ-012 ld_data  input  16  host loader data.
REQ-013 ld_done  input  1  host pulse ending the load phase.
REQ-014 cpu_rst  output  1  reset to the NanoCPU; high until the RUN state.
REQ-015 busy  output  1  high while in the CLEAR state.
REQ-016 io_out  output  16  last value the CPU wrote to IO_ADDR.
REQ-017 io_strobe  output  1  one-cycle pulse on each accepted IO_ADDR write.
REQ-018 wp_fault  output  1  one-cycle pulse on each blocked protected write.

Function
REQ-019 The FSM SHALL have three states, entered in order: CLEAR, LOAD, RUN.
REQ-020 CLEAR SHALL write 16'h0000 to one word per cycle using an 8-bit counter that runs 0..255, then move to LOAD after exactly 256 cycles.
REQ-021 LOAD SHALL store ld_data at ld_addr in every cycle where ld_valid=1, with no protection check.
REQ-022 The FSM SHALL go from LOAD to RUN on the cycle after ld_done=1; if ld_valid=1 in the same cycle, that word SHALL be written first.
REQ-023 cpu_rst SHALL be 1 in CLEAR and LOAD and SHALL be 0 from the first RUN cycle onward.
REQ-024 busy SHALL be 1 only in CLEAR.
REQ-025 In RUN, ld_valid and ld_done SHALL be ignored.
REQ-026 In RUN with ce=1, dataR SHALL equal mem[address] combinationally (0-cycle latency).
REQ-027 For address=IO_ADDR, dataR SHALL return io_out; in all other cases (ce=0, or not in RUN) dataR SHALL be 16'h0000.
REQ-028 In RUN, ce=1 & we=1 & address>WP_TOP & address!=IO_ADDR SHALL write dataW to mem[address] at the clock edge.
REQ-029 In RUN, ce=1 & we=1 & address=IO_ADDR SHALL load io_out with dataW and pulse io_strobe for the next cycle; the array word SHALL be left unchanged.
REQ-030 In RUN, ce=1 & we=1 & address<=WP_TOP SHALL leave memory unchanged and pulse wp_fault for one cycle.
REQ-031 A read of an address written in the previous cycle SHALL return the new value.
REQ-032 Back-to-back writes SHALL each be accepted, one per cycle, with no wait states.

Reset
REQ-033 rst=1 SHALL force, asynchronously: state CLEAR, counter 0, cpu_rst 1, busy 1, io_out 0, io_strobe 0, wp_fault 0.
REQ-034 Reset asserted in any state, including mid-CLEAR or mid-LOAD, SHALL restart the full 256-cycle clear.
REQ-035 Array contents SHALL NOT be reset directly; only CLEAR zeroes them.

Configuration
REQ-036 Macro NANO_MEM_STATS_EN, when defined, SHALL add outputs rd_count[15:0] and wr_count[15:0].
REQ-037 The counters SHALL count accepted RUN reads (ce=1 & we=0) and accepted RUN writes, SHALL saturate at 16'hFFFF, and SHALL reset to 0.
REQ-038 Without NANO_MEM_STATS_EN, neither the ports nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-039 Package nano_pkg SHALL hold addr_t (8 bits), word_t (16 bits), the mem_state_t enum {CLEAR, LOAD, RUN} and the default IO_ADDR constant.
REQ-040 Storage SHALL be a sub-module nano_mem_array: 256 x 16, one synchronous write port, one asynchronous read port; the write mux (clear/loader/CPU) SHALL sit in nano_mem.

Verification
REQ-041 Reset, then idle -> busy=1 for 256 cycles, then LOAD; a debug-port read of every word returns 0.
REQ-042 LOAD 0:'h4000, 30:'h0006, then ld_done -> cpu_rst falls the next cycle; a RUN read of address 30 gives 'h0006.
REQ-043 RUN write 'hABCD to address 8'h05 -> no change, wp_fault=1 for one cycle; write to 8'h20 -> reading 8'h20 gives 'hABCD.
REQ-044 RUN write 'h000E to 8'hFF -> io_out='h000E, io_strobe high for exactly one cycle; reading 8'hFF gives 'h000E.
REQ-045 rst pulsed mid-LOAD after 3 words -> CLEAR restarts and those 3 words read 0 after the clear.
REQ-046 With NANO_MEM_STATS_EN defined, 5 reads and 3 writes (one of them blocked) -> rd_count=5, wr_count=2.
